boot_loader_ctrl: RTL and testbench

BOOT_LOADER_CTRL -- requirements
Module: boot_loader_ctrl

---
 rtl/boot_loader_ctrl.sv | 162 ++++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// Boot loader controller: assembles a little-endian byte stream (start PC, word count,
// program words) into instruction-memory writes, then releases the CPU from reset.
module boot_loader_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  input  logic        i_reload,
  output logic        o_imem_we,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_wdata,
  output logic        o_cpu_reset,
  output logic [31:0] o_startPC,
  output logic        o_busy,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_PC, S_CNT, S_DATA, S_WRITE, S_RUN, S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] count_q, count_d;
  logic [31:0] index_q, index_d;
  logic [31:0] start_pc_q, start_pc_d;
  logic        cpu_reset_q;

  logic        take;
  logic        last_byte;
  logic [31:0] full_word;
  logic [31:0] index_inc;

  assign take      = i_byte_valid && o_byte_ready;
  assign last_byte = take && (byte_cnt_q == 2'd3);
  // Value of the field being assembled, valid only when its 4th byte is on i_byte.
  assign full_word = {i_byte, asm_q[23:0]};
  assign index_inc = index_q + 32'd1;

  // Next-state logic: byte assembly, field decode and word sequencing.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    count_d    = count_q;
    index_d    = index_q;
    start_pc_d = start_pc_q;

    if (take) begin
      asm_d[{byte_cnt_q, 3'b000} +: 8] = i_byte;
      byte_cnt_d = byte_cnt_q + 2'd1;
    end

    case (state_q)
      S_PC: begin
        if (last_byte) begin
          start_pc_d = full_word;
          state_d    = S_CNT;
        end
      end
      S_CNT: begin
        if (last_byte) begin
          count_d = full_word;
          index_d = 32'd0;
          if (full_word == 32'd0) begin
            state_d = S_RUN;
          end else if (full_word > 32'(MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        index_d = index_inc;
        state_d = (index_inc == count_q) ? S_RUN : S_DATA;
      end
      S_RUN: begin
        if (i_reload) begin
          state_d = S_PC;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_PC;
      end
    endcase

    // Every state change restarts byte-lane selection at lane 0.
    if (state_d != state_q) begin
      byte_cnt_d = 2'd0;
    end
  end

  // State and datapath registers; cpu reset is registered from the next state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_PC;
      byte_cnt_q  <= 2'd0;
      asm_q       <= 32'd0;
      count_q     <= 32'd0;
      index_q     <= 32'd0;
      start_pc_q  <= 32'd0;
      cpu_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      count_q     <= count_d;
      index_q     <= index_d;
      start_pc_q  <= start_pc_d;
      cpu_reset_q <= (state_d != S_RUN);
    end
  end

  // Outputs decoded from the registered state.
  always_comb begin
    o_byte_ready = 1'b0;
    o_imem_we    = 1'b0;
    o_busy       = 1'b0;
    o_error      = 1'b0;
    case (state_q)
      S_PC: begin
        o_byte_ready = 1'b1;
        // Idle until the first PC byte arrives.
        o_busy       = (byte_cnt_q != 2'd0);
      end
      S_CNT, S_DATA: begin
        o_byte_ready = 1'b1;
        o_busy       = 1'b1;
      end
      S_WRITE: begin
        o_imem_we = 1'b1;
        o_busy    = 1'b1;
      end
      S_ERR: begin
        o_error = 1'b1;
      end
      default: begin
        o_byte_ready = 1'b0;
      end
    endcase
  end

  assign o_imem_addr  = BASE_ADDR + {index_q[29:0], 2'b00};
  assign o_imem_wdata = asm_q;
  assign o_cpu_reset  = cpu_reset_q;
  assign o_startPC    = start_pc_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: expected writes are queued as the stream is
// driven and compared when the loader strobes instruction memory.
module tb_boot_loader_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MAXW = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic        i_reload;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;
  logic        o_cpu_reset;
  logic [31:0] o_startPC;
  logic        o_busy;
  logic        o_error;

  int n_checks = 0;
  int n_fails  = 0;
  logic [63:0] exp_q[$];
  logic        prev_we = 1'b0;

  boot_loader_ctrl #(
    .BASE_ADDR (BASE),
    .MAX_WORDS (MAXW)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_byte       (i_byte),
    .i_byte_valid (i_byte_valid),
    .o_byte_ready (o_byte_ready),
    .i_reload     (i_reload),
    .o_imem_we    (o_imem_we),
    .o_imem_addr  (o_imem_addr),
    .o_imem_wdata (o_imem_wdata),
    .o_cpu_reset  (o_cpu_reset),
    .o_startPC    (o_startPC),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard side: compare every write strobe against the oldest queued expectation.
  always @(negedge i_clk) begin
    if (!i_reset && o_imem_we) begin
      check_eq("ready_low_in_write", o_byte_ready, 0);
      check_eq("we_single_cycle", prev_we, 0);
      check_eq("write_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check_eq("write_addr_data", {o_imem_addr, o_imem_wdata}, exp_q.pop_front());
      end
    end
    prev_we = o_imem_we && !i_reset;
  end

  // Present one byte (optionally after idle cycles) and return at the negedge after it is taken.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    logic r;
    int   n;
    if (gaps) begin
      i_byte_valid = 1'b0;
      repeat (1 + $urandom_range(0, 2)) @(negedge i_clk);
    end
    i_byte       = b;
    i_byte_valid = 1'b1;
    n = 0;
    r = 1'b0;
    while (!r && n < 50) begin
      r = o_byte_ready;
      @(negedge i_clk);
      n++;
    end
    check_eq("byte_accepted", r, 1);
    i_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
  endtask

  // Drive a whole stream, queue its expected writes, and verify the release into run.
  task automatic load(input logic [31:0] pc, input logic [31:0] words[$], input bit gaps);
    send_word(pc, gaps);
    send_word(32'(words.size()), gaps);
    foreach (words[i]) begin
      exp_q.push_back({BASE + 32'(4 * i), words[i]});
      send_word(words[i], gaps);
    end
    if (words.size() != 0) begin
      check_eq("cpu_reset_held_in_write", o_cpu_reset, 1);
      @(negedge i_clk);
    end
    check_eq("cpu_reset_released", o_cpu_reset, 0);
    check_eq("start_pc", o_startPC, pc);
    check_eq("busy_in_run", o_busy, 0);
    check_eq("all_writes_seen", exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    #2 i_reset = 1'b1;
    #1;
    check_eq("rst_we", o_imem_we, 0);
    check_eq("rst_cpu_reset", o_cpu_reset, 1);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_error", o_error, 0);
    check_eq("rst_start_pc", o_startPC, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    logic [31:0] w[$];
    i_reset = 1'b1;
    i_byte = 8'h00;
    i_byte_valid = 1'b0;
    i_reload = 1'b0;
    #3;
    check_eq("init_cpu_reset", o_cpu_reset, 1);
    check_eq("init_start_pc", o_startPC, 0);
    check_eq("init_we", o_imem_we, 0);
    check_eq("init_error", o_error, 0);
    check_eq("init_busy", o_busy, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    check_eq("idle_ready", o_byte_ready, 1);
    check_eq("idle_busy", o_busy, 0);

    // Reference two-word program, gap-free.
    send_byte(8'h00, 1'b0);
    check_eq("busy_after_first_byte", o_busy, 1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check_eq("pc_registered", o_startPC, 32'h100);
    w = '{32'h0000_0013, 32'h0010_0093};
    send_word(32'd2, 1'b0);
    foreach (w[i]) begin
      exp_q.push_back({BASE + 32'(4 * i), w[i]});
      send_word(w[i], 1'b0);
    end
    @(negedge i_clk);
    check_eq("ref_cpu_reset", o_cpu_reset, 0);
    check_eq("ref_writes", exp_q.size(), 0);

    // Reload honoured in run: cpu held on the next edge, old PC kept until overwritten.
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    check_eq("reload_cpu_reset", o_cpu_reset, 1);
    check_eq("reload_pc_kept", o_startPC, 32'h100);
    check_eq("reload_ready", o_byte_ready, 1);
    check_eq("reload_busy", o_busy, 0);
    // Same image with random valid gaps must land identically.
    load(32'h100, w, 1'b1);

    // Count zero goes straight to run with no write.
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    w = {};
    load(32'h0000_8000, w, 1'b0);

    // Exactly MAX_WORDS is legal.
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    w = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0F0F, 32'h0000_0001};
    load(32'hFFFF_FFFC, w, 1'b1);

    // Reset mid-word aborts the load; only word 0 may be written.
    pulse_reset();
    exp_q.push_back({BASE, 32'hCAFE_F00D});
    send_word(32'h0000_0200, 1'b0);
    send_word(32'd2, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_reset();
    repeat (3) @(negedge i_clk);
    check_eq("abort_no_second_write", exp_q.size(), 0);
    check_eq("abort_cpu_reset", o_cpu_reset, 1);
    w = '{32'h0BAD_C0DE, 32'h7777_8888};
    load(32'h0000_0400, w, 1'b0);

    // MAX_WORDS+1 is illegal and terminal.
    i_reload = 1'b1;
    @(negedge i_clk);
    i_reload = 1'b0;
    send_word(32'h0000_0040, 1'b0);
    send_word(32'd5, 1'b0);
    check_eq("err_flag", o_error, 1);
    check_eq("err_ready", o_byte_ready, 0);
    check_eq("err_cpu_reset", o_cpu_reset, 1);
    i_byte = 8'h55;
    i_byte_valid = 1'b1;
    i_reload = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge i_clk);
      i_reload = 1'b0;
      check_eq("err_stays", {o_error, o_byte_ready, o_cpu_reset, o_busy}, 4'b1010);
    end
    i_byte_valid = 1'b0;
    pulse_reset();
    check_eq("err_cleared", o_error, 0);
    w = '{32'h0000_0013};
    load(32'h0000_0000, w, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
